// File: rtl/wide_add_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_pkg
// Shared definitions for the multi-precision add/subtract sequencer.
//   WORD_W       : width of one adder slice (16 bits)
//   word_t       : one slice of an operand or result
//   wadd_state_t : sequencer states (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package wide_add_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wadd_state_t;

endpackage : wide_add_pkg

// File: rtl/prefixadder16bit.sv
// -----------------------------------------------------------------------------
// prefixadder16bit
// Combinational 16-bit Kogge-Stone parallel-prefix adder.
// Ports:
//   a, b  in  16  addends
//   cin   in  1   carry-in
//   s     out 16  sum
//   cout  out 1   carry out of bit 15
// -----------------------------------------------------------------------------
module prefixadder16bit
  import wide_add_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  // Group generate/propagate after each of the four prefix levels.
  logic [15:0] g_s [0:4];
  logic [15:0] p_s [0:4];
  logic [15:0] c_s;

  assign g_s[0] = a & b;
  assign p_s[0] = a ^ b;

  // Each level doubles the span: bit i merges with bit i-D. Bits below D have
  // no partner, so their propagate is kept by OR-ing in a low mask.
  for (genvar lvl = 0; lvl < 4; lvl++) begin : g_level
    localparam int D = 1 << lvl;
    assign g_s[lvl+1] = g_s[lvl] | (p_s[lvl] & (g_s[lvl] << D));
    assign p_s[lvl+1] = p_s[lvl] & ((p_s[lvl] << D) | 16'((1 << D) - 1));
  end

  // Carry into bit i is the group [i-1:0] term combined with cin.
  assign c_s  = {g_s[4][14:0] | (p_s[4][14:0] & {15{cin}}), cin};
  assign s    = p_s[0] ^ c_s;
  assign cout = g_s[4][15] | (p_s[4][15] & cin);

endmodule : prefixadder16bit

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
// Multi-precision add/subtract built around one 16-bit prefix adder. An
// accepted request is processed one slice per cycle, least significant first,
// with the carry held in a register between cycles.
// Ports:
//   clk        in   1          clock, posedge
//   reset      in   1          synchronous active-high reset
//   in_valid   in   1          operand request
//   in_ready   out  1          request can be accepted (IDLE only)
//   a, b       in   16*WORDS   operands, sampled on accept
//   cin        in   1          carry-in, sampled on accept
//   sub        in   1          1 = A - B, sampled on accept
//   out_valid  out  1          result available
//   out_ready  in   1          consumer takes the result
//   sum        out  16*WORDS   result
//   cout       out  1          carry out of MSB (subtract: 1 = no borrow)
//   ovf        out  1          signed overflow
// -----------------------------------------------------------------------------
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int OP_W  = WORD_W * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  wadd_state_t      state_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [OP_W-1:0]  a_r;
  logic [OP_W-1:0]  b_r;
  logic [OP_W-1:0]  sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [31:0]      base_s;
  word_t            a_slice_s;
  word_t            b_slice_s;
  word_t            adder_s_s;
  logic             adder_cout_s;
  logic             last_s;
  logic             ovf_s;

  // Select the current slice of the internal operand copies.
  always_comb begin
    base_s    = 32'(idx_r) * 32'(WORD_W);
    a_slice_s = a_r[base_s +: WORD_W];
    b_slice_s = b_r[base_s +: WORD_W];
    last_s    = (idx_r == LAST_IDX);
    // Only meaningful on the last slice, where bit 15 is the operand MSB.
    ovf_s     = (a_slice_s[WORD_W-1] == b_slice_s[WORD_W-1]) &&
                (adder_s_s[WORD_W-1] != a_slice_s[WORD_W-1]);
  end

  prefixadder16bit u_slice_adder (
    .a    (a_slice_s),
    .b    (b_slice_s),
    .cin  (carry_r),
    .s    (adder_s_s),
    .cout (adder_cout_s)
  );

  // Sequencer FSM, operand capture and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            // Subtraction is A + ~B + 1; the +1 comes in through the carry.
            b_r        <= sub ? ~b : b;
            carry_r    <= cin ^ sub;
            idx_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            state_r    <= IDLE;
          end
        end
        RUN: begin
          sum_r[base_s +: WORD_W] <= adder_s_s;
          carry_r                 <= adder_cout_s;
          if (last_s) begin
            cout_r      <= adder_cout_s;
            ovf_r       <= ovf_s;
            // Park idx at zero so it never steps past the last slice.
            idx_r       <= '0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r       <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule : wide_add_sequencer

// File: tb/tb_wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wide_add_sequencer
// Directed bench for wide_add_sequencer with WORDS=4 and hand-computed results.
// -----------------------------------------------------------------------------
module tb_wide_add_sequencer;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a_i = 64'd0;
  logic [63:0] b_i = 64'd0;
  logic        cin_i = 1'b0;
  logic        sub_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .cin       (cin_i),
    .sub       (sub_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request and let it be accepted; scramble the inputs afterwards.
  task automatic do_accept(input logic [63:0] av, input logic [63:0] bv,
                           input logic cv, input logic sv);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    a_i = av; b_i = bv; cin_i = cv; sub_i = sv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_i = {$urandom, $urandom};
    b_i = {$urandom, $urandom};
    cin_i = 1'($urandom);
    sub_i = 1'($urandom);
    check("in_ready_low_after_accept", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic wait_result(input string tag, input logic [63:0] es,
                             input logic ec, input logic eo);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(WORDS));
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_in_ready_rise"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);

    // Carry out of slice 0 into slice 1.
    do_accept(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
    wait_result("add_ffff", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    release_result("add_ffff");

    // Carry ripples through every slice.
    do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_result("add_allones", 64'd0, 1'b1, 1'b0);
    release_result("add_allones");

    // 5 - 7 borrows.
    do_accept(64'd5, 64'd7, 1'b0, 1'b1);
    wait_result("sub_5_7", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    release_result("sub_5_7");

    // 7 - 5 no borrow.
    do_accept(64'd7, 64'd5, 1'b0, 1'b1);
    wait_result("sub_7_5", 64'd2, 1'b1, 1'b0);
    release_result("sub_7_5");

    // Positive overflow.
    do_accept(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_result("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    release_result("add_ovf");

    // Negative overflow on subtract.
    do_accept(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
    wait_result("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    release_result("sub_ovf");

    // Hold the result in DONE with out_ready low.
    do_accept(64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002, 1'b1, 1'b0);
    wait_result("hold", 64'h0000_0003_0000_0004, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_sum", sum, 64'h0000_0003_0000_0004);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    release_result("hold");

    // Back-to-back with cin=1: 0xAAAA.. + 0x5555.. + 1 wraps to zero.
    do_accept(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
    wait_result("b2b", 64'd0, 1'b1, 1'b0);
    release_result("b2b");

    // Reset while idx=2 discards the operation.
    do_accept(64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_sum", sum, 64'd0);
    check("midrst_cout", {63'd0, cout}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_result", {63'd0, out_valid}, 64'd0);
    end
    do_accept(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    wait_result("after_rst", 64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
    release_result("after_rst");

    // Reset and in_valid on the same edge: nothing is accepted.
    a_i = 64'd1; b_i = 64'd1; cin_i = 1'b0; sub_i = 1'b0;
    in_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b0;
    check("rst_vs_valid_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("rst_vs_valid_no_result", {63'd0, out_valid}, 64'd0);
    check("rst_vs_valid_in_ready_idle", {63'd0, in_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wide_add_sequencer
